// File: rtl/ser_tx_pkg.sv
// ser_tx_pkg: shared FSM state encoding and frame-length helper for the serial transmitter
package ser_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    // bits per frame: start + payload + stop
    function automatic int frame_len(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/ser_tx_if.sv
// ser_tx_if: valid/ready word handshake between an upstream producer and the transmitter
interface ser_tx_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ser_tx_tick.sv
// ser_tx_tick: baud divider and bit counter with synchronous clear
module ser_tx_tick #(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick,
    output logic last_bit
);
    localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam int NW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    logic [BW-1:0] baud;
    logic [NW-1:0] bit_cnt;

    assign bit_tick = baud == BW'(BAUD_DIV - 1);
    assign last_bit = bit_tick && bit_cnt == NW'(DATA_W - 1);

    // baud counter wraps every BAUD_DIV cycles; bit counter advances once per bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            baud    <= '0;
            bit_cnt <= '0;
        end else begin
            baud <= bit_tick ? '0 : baud + 1'b1;
            if (bit_tick) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ser_tx_ctrl.sv
// ser_tx_ctrl: double-buffered parallel-to-serial framer (start, LSB-first data, stop)
module ser_tx_ctrl
    import ser_tx_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    ser_tx_if.slave  up,
    output logic     ser_out,
    output logic     busy,
    output logic     frame_done
);
    state_t            state, state_nx;
    logic              hold_full;
    logic [DATA_W-1:0] hold, shifter;
    logic              bit_tick, last_bit, clr, accept, transfer;

    assign up.in_ready = !hold_full;
    assign accept      = up.in_valid && !hold_full;
    assign transfer    = hold_full && (state == IDLE || (state == STOP && bit_tick));
    assign clr         = state == IDLE || state_nx != state;
    assign busy        = state != IDLE;
    assign frame_done  = state == STOP && bit_tick;

    // next state: START/DATA/STOP advance on bit boundaries, STOP chains straight into START when a word waits
    always_comb begin
        state_nx = state == IDLE  ? (hold_full ? START : IDLE) :
                   !bit_tick      ? state :
                   state == START ? DATA :
                   state == DATA  ? (last_bit ? STOP : DATA) :
                                    (hold_full ? START : IDLE);
    end

    // line level: start bit low, payload from shifter LSB, idle and stop high
    always_comb begin
        ser_out = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
    end

    ser_tx_tick #(.DATA_W(DATA_W), .BAUD_DIV(BAUD_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bit_tick (bit_tick),
        .last_bit (last_bit)
    );

    // FSM state, holding register and parallel-load right-shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            hold      <= '0;
            shifter   <= '0;
        end else begin
            state     <= state_nx;
            hold_full <= accept || (hold_full && !transfer);
            hold      <= accept ? up.in_data : hold;
            shifter   <= transfer ? hold : (state == DATA && bit_tick) ? shifter >> 1 : shifter;
        end
    end
endmodule

// File: tb/tb_ser_tx_ctrl.sv
// tb_ser_tx_ctrl: directed and random checks of two transmitter configurations against a frame-position model
module tb_ser_tx_ctrl;
    import ser_tx_pkg::*;

    localparam int W0 = 4, B0 = 4, W1 = 8, B1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  vld;
    logic [15:0] dat [2];
    logic [1:0]  so, bz, fd, rdy;
    int          total = 0, bad = 0;
    int          fdcnt [2];
    logic        chk_en;

    always #5 clk = ~clk;

    ser_tx_if #(.DATA_W(W0)) ia ();
    ser_tx_if #(.DATA_W(W1)) ib ();

    assign ia.in_valid = vld[0];
    assign ia.in_data  = dat[0][W0-1:0];
    assign ib.in_valid = vld[1];
    assign ib.in_data  = dat[1][W1-1:0];
    assign rdy         = {ib.in_ready, ia.in_ready};

    ser_tx_ctrl #(.DATA_W(W0), .BAUD_DIV(B0)) dut_a (
        .clk(clk), .rst_n(rst_n), .up(ia.slave), .ser_out(so[0]), .busy(bz[0]), .frame_done(fd[0])
    );
    ser_tx_ctrl #(.DATA_W(W1), .BAUD_DIV(B1)) dut_b (
        .clk(clk), .rst_n(rst_n), .up(ib.slave), .ser_out(so[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    // model: one holding slot plus a frame in flight, tracked as a cycle position within the frame
    typedef struct packed {
        logic        hf;
        logic [15:0] hold;
        logic        act;
        logic [15:0] pos;
        logic [15:0] word;
    } mdl_t;

    mdl_t m [2];

    function automatic int wd(input int k);
        return k == 0 ? W0 : W1;
    endfunction

    function automatic int bd(input int k);
        return k == 0 ? B0 : B1;
    endfunction

    function automatic int flen(input int k);
        return frame_len(wd(k)) * bd(k);
    endfunction

    function automatic mdl_t step(input mdl_t x, input int k, input logic v, input logic [15:0] d);
        mdl_t y = x;
        if (x.act && int'(x.pos) != flen(k) - 1) y.pos = x.pos + 16'd1;
        else if (x.hf) begin
            y.act  = 1'b1;
            y.pos  = '0;
            y.word = x.hold;
            y.hf   = 1'b0;
        end else y.act = 1'b0;
        if (v && !x.hf) begin
            y.hf   = 1'b1;
            y.hold = d;
        end
        return y;
    endfunction

    function automatic logic exp_ser(input mdl_t x, input int k);
        int j = int'(x.pos) / bd(k);
        if (!x.act) return 1'b1;
        if (j == 0) return 1'b0;
        if (j <= wd(k)) return x.word[j-1];
        return 1'b1;
    endfunction

    // reference model advances on the same edges as the DUT and resets asynchronously with it
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) m[k] <= !rst_n ? '0 : step(m[k], k, vld[k], dat[k]);
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (chk_en) for (int k = 0; k < 2; k++) begin
            chk($sformatf("ser_out%0d", k), 32'(so[k]), 32'(exp_ser(m[k], k)));
            chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(m[k].act));
            chk($sformatf("frame_done%0d", k), 32'(fd[k]), 32'(m[k].act && int'(m[k].pos) == flen(k) - 1));
            chk($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(!m[k].hf));
        end
        for (int k = 0; k < 2; k++) if (fd[k]) fdcnt[k]++;
    endtask

    task automatic send(input int k, input logic [15:0] d);
        logic r;
        int   n = 0;
        vld[k] = 1'b1;
        dat[k] = d;
        do begin
            r = rdy[k];
            cyc();
            n++;
        end while (!r && n < 300);
        vld[k] = 1'b0;
        chk($sformatf("accept%0d", k), 32'(r), 32'd1);
    endtask

    task automatic wait_fd(input int k, input int target, input int budget);
        int n = 0;
        while (fdcnt[k] < target && n < budget) begin
            cyc();
            n++;
        end
        chk($sformatf("fd_wait%0d", k), 32'(fdcnt[k]), 32'(target));
    endtask

    initial begin
        int          base, gap, n;
        int          base_r [2];
        int          sent [2];
        logic [15:0] cap;
        vld = '0;
        dat[0] = '0;
        dat[1] = '0;
        fdcnt[0] = 0;
        fdcnt[1] = 0;
        sent[0] = 0;
        sent[1] = 0;
        chk_en = 1'b0;
        cyc();
        cyc();
        chk("rst_ser_out", 32'(so), 32'h3);
        chk("rst_in_ready", 32'(rdy), 32'h3);
        chk("rst_busy", 32'(bz), 32'h0);
        chk("rst_frame_done", 32'(fd), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // single word 4'hA, accepted on the first edge after reset release
        base = fdcnt[0];
        send(0, 16'hA);
        chk("lat_still_idle", 32'(so[0]), 32'd1);
        chk("lat_hold_full", 32'(rdy[0]), 32'd0);
        cyc();
        chk("lat_start_bit", 32'(so[0]), 32'd0);
        chk("lat_busy", 32'(bz[0]), 32'd1);
        cap = '0;
        for (int j = 0; j < 6; j++) begin
            cap[j] = so[0];
            repeat (B0) cyc();
        end
        chk("frame_A", 32'(cap[5:0]), 32'b110100);
        chk("frame_A_done", 32'(fdcnt[0] - base), 32'd1);
        chk("frame_A_idle", 32'(bz[0]), 32'd0);

        // back-to-back: 4'h3, then 4'hC during the first data bit
        base = fdcnt[0];
        send(0, 16'h3);
        cyc();
        repeat (B0 + 1) cyc();
        send(0, 16'hC);
        chk("b2b_ready_low", 32'(rdy[0]), 32'd0);
        gap = 0;
        n = 0;
        while (fdcnt[0] - base < 2 && n < 200) begin
            if (!bz[0]) gap++;
            cyc();
            n++;
        end
        chk("b2b_frames", 32'(fdcnt[0] - base), 32'd2);
        chk("b2b_gap", 32'(gap), 32'd0);
        repeat (3) cyc();

        // backpressure: hold full while 4'hF waits with valid high
        base = fdcnt[0];
        send(0, 16'h5);
        repeat (2) cyc();
        send(0, 16'h6);
        send(0, 16'hF);
        chk("bp_hold_refilled", 32'(rdy[0]), 32'd0);
        wait_fd(0, base + 3, 300);
        repeat (3) cyc();
        chk("bp_frames", 32'(fdcnt[0] - base), 32'd3);

        // reset during the second data bit with a second word already held
        base = fdcnt[0];
        send(0, 16'h9);
        cyc();
        send(0, 16'h6);
        repeat (8) cyc();
        chk("pre_rst_data", 32'(so[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ser_out", 32'(so[0]), 32'd1);
        chk("async_busy", 32'(bz[0]), 32'd0);
        chk("async_in_ready", 32'(rdy[0]), 32'd1);
        chk("async_frame_done", 32'(fd[0]), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        chk("rst_no_done", 32'(fdcnt[0] - base), 32'd0);
        send(0, 16'h6);
        chk("post_rst_accept", 32'(rdy[0]), 32'd0);
        cyc();
        cap = '0;
        for (int j = 0; j < 6; j++) begin
            cap[j] = so[0];
            repeat (B0) cyc();
        end
        chk("frame_post_rst", 32'(cap[5:0]), 32'b101100);
        repeat (30) cyc();
        chk("post_rst_frames", 32'(fdcnt[0] - base), 32'd1);

        // BAUD_DIV=1, DATA_W=8, word 8'h81
        base = fdcnt[1];
        send(1, 16'h81);
        chk("b1_still_idle", 32'(so[1]), 32'd1);
        cyc();
        cap = '0;
        for (int j = 0; j < 10; j++) begin
            cap[j] = so[1];
            cyc();
        end
        chk("frame_81", 32'(cap[9:0]), 32'b1100000010);
        chk("frame_81_done", 32'(fdcnt[1] - base), 32'd1);

        // random words and gaps on both instances
        base_r[0] = fdcnt[0];
        base_r[1] = fdcnt[1];
        for (int i = 0; i < 30; i++) begin
            int k = int'($urandom_range(0, 1));
            send(k, 16'($urandom));
            sent[k]++;
            repeat ($urandom_range(0, 30)) cyc();
        end
        n = 0;
        while ((bz != 2'b00 || rdy != 2'b11) && n < 400) begin
            cyc();
            n++;
        end
        chk("rand_drained", 32'({bz, rdy}), 32'b0011);
        chk("rand_frames0", 32'(fdcnt[0] - base_r[0]), 32'(sent[0]));
        chk("rand_frames1", 32'(fdcnt[1] - base_r[1]), 32'(sent[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ser_tx_ctrl.md
SER_TX_CTRL -- requirements
Module: ser_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning payload bits per frame (range 1..16).
REQ-002 The block SHALL have parameter BAUD_DIV, default 4, meaning clock cycles per serial bit (range 1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk is the only clock, and rst_n asserted low resets all state immediately, independent of clk.
REQ-004 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_valid, input, 1, upstream word present on in_data.
REQ-007 Port in_data, input, DATA_W, parallel payload word.
REQ-008 Port in_ready, output, 1, the holding buffer can accept a word this cycle.
REQ-009 Port ser_out, output, 1, framed serial line; idle level high.
REQ-010 Port busy, output, 1, a frame is being shifted out.
REQ-011 Port frame_done, output, 1, one-cycle pulse on the last cycle of each stop bit.

Function
REQ-012 A frame SHALL be: one start bit (0), then DATA_W data bits LSB first, then one stop bit (1); each bit is held for exactly BAUD_DIV cycles.
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1, and is then stored in a one-entry holding register.
REQ-014 in_ready SHALL equal NOT hold_full, driven from registered state only, with no combinational path from in_valid.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, and STOP.
REQ-016 IDLE -> START: when hold_full=1, the hold word moves into the shift register, hold_full clears, and ser_out=0 from the next cycle.
REQ-017 Latency SHALL be: word accepted at edge N in IDLE -> first start-bit cycle on ser_out at cycle N+2 (one cycle to hold, one to shifter).
REQ-018 START -> DATA SHALL occur after BAUD_DIV cycles.
REQ-019 DATA -> STOP SHALL occur after DATA_W*BAUD_DIV cycles; the shifter shifts right by one bit every BAUD_DIV cycles, and ser_out = shifter[0].
REQ-020 STOP -> START (no idle gap) SHALL occur at the end of the stop bit if hold_full=1; otherwise STOP -> IDLE.
REQ-021 The holding register SHALL accept a new word during any state (START, DATA, or STOP) while hold_full=0; this is double buffering.
REQ-022 If an accept and a transfer to the shifter occur on the same edge, the incoming word SHALL be written and hold_full SHALL remain 1.
REQ-023 busy SHALL be 1 in START, DATA, and STOP, and 0 in IDLE.
REQ-024 frame_done SHALL pulse exactly once per frame, including back-to-back frames.
REQ-025 The baud counter SHALL count 0..BAUD_DIV-1 and wrap; the bit counter SHALL count 0..DATA_W-1. Both SHALL clear on every state entry.
REQ-026 With BAUD_DIV=1, every state SHALL advance every cycle, and the frame SHALL be DATA_W+2 cycles long.
REQ-027 in_valid=1 while in_ready=0 SHALL have no effect; upstream holds the word until accepted.

Reset
REQ-028 While rst_n=0: ser_out=1, in_ready=1, busy=0, frame_done=0, state=IDLE, hold_full=0, counters=0, shifter=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame and force ser_out high immediately (asynchronously); the held word is discarded.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 Shared package ser_tx_pkg SHALL hold the FSM state type (IDLE/START/DATA/STOP) and the frame-length constant function (DATA_W+2).
REQ-032 The baud and bit counting SHALL live in one sub-module, ser_tx_tick, which outputs a bit_tick pulse every BAUD_DIV cycles with a synchronous clear.
REQ-033 The shift register is internal, and its load/shift semantics SHALL match the team's parallel-load right-shift register.

Verification
REQ-034 Single word: DATA_W=4, BAUD_DIV=4, accept 4'hA -> ser_out reads 0,0,1,0,1,1, with each level held 4 cycles; start bit at cycle N+2; one frame_done.
REQ-035 Back-to-back: accept 4'h3, then 4'hC during DATA -> two frames with no idle-high gap between them; in_ready=0 from the second accept until transfer; two frame_done pulses.
REQ-036 Backpressure: hold full, in_valid held high with 4'hF -> no accept; word accepted the cycle after the transfer; no word lost or duplicated.
REQ-037 BAUD_DIV=1, DATA_W=8, accept 8'h81 -> ser_out reads 0,1,0,0,0,0,0,0,1,1 over 10 consecutive cycles.
REQ-038 Reset mid-DATA: assert rst_n low during the 2nd data bit -> ser_out=1 within the same cycle; busy=0; in_ready=1; no frame_done; the next accepted word frames correctly.
